// File: rtl/user_module_serial_frame_rx.sv
// Serial frame receiver: assembles sync-marked, LSB-first words from a 1-bit stream.
// Optional even-parity bit after the data bits is enabled by defining FRAME_RX_PARITY_EN.
module user_module_serial_frame_rx #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [3:0] LastIdx = 4'(DATA_BITS - 1);

`ifdef FRAME_RX_PARITY_EN
    localparam state_e AfterData = StParity;
    logic par_err_q, par_err_d;
`else
    localparam state_e AfterData = StDone;
`endif
    // A 1-bit frame is complete as soon as its sync bit is taken.
    localparam state_e AfterStart = (DATA_BITS == 1) ? AfterData : StShift;

    logic       clk, rst_n, din, din_valid, sync, rd;
    logic [1:0] view_sel;
    logic       start;

    assign clk       = io_in[0];
    assign rst_n     = io_in[1];
    assign din       = io_in[2];
    assign din_valid = io_in[3];
    assign sync      = io_in[4];
    assign rd        = io_in[5];
    assign view_sel  = io_in[7:6];
    assign start     = din_valid & sync;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       rx_valid_q, rx_valid_d;
    logic       perr_q, perr_d;
    logic       ovf_q, ovf_d;
    logic       abrt_q, abrt_d;
    logic       busy;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        bitcnt_d   = bitcnt_q;
        rx_valid_d = rd ? 1'b0 : rx_valid_q;
        perr_d     = rd ? 1'b0 : perr_q;
        ovf_d      = rd ? 1'b0 : ovf_q;
        abrt_d     = rd ? 1'b0 : abrt_q;
`ifdef FRAME_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d  = {7'b0, din};
                    bitcnt_d = 4'd1;
                    state_d  = AfterStart;
                end
            end
            StShift: begin
                if (start) begin
                    abrt_d   = 1'b1;
                    shreg_d  = {7'b0, din};
                    bitcnt_d = 4'd1;
                    state_d  = AfterStart;
                end else if (din_valid) begin
                    shreg_d[bitcnt_q[2:0]] = din;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == LastIdx) begin
                        state_d = AfterData;
                    end
                end
            end
            StParity: begin
`ifdef FRAME_RX_PARITY_EN
                if (start) begin
                    abrt_d   = 1'b1;
                    shreg_d  = {7'b0, din};
                    bitcnt_d = 4'd1;
                    state_d  = AfterStart;
                end else if (din_valid) begin
                    par_err_d = (^shreg_q) ^ din;
                    state_d   = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                // Commit wins over a coincident rd.
                data_d     = shreg_q;
                rx_valid_d = 1'b1;
`ifdef FRAME_RX_PARITY_EN
                perr_d     = par_err_q;
`else
                perr_d     = 1'b0;
`endif
                ovf_d      = rd ? 1'b0 : (ovf_q | rx_valid_q);
                if (start) begin
                    shreg_d  = {7'b0, din};
                    bitcnt_d = 4'd1;
                    state_d  = AfterStart;
                end else begin
                    bitcnt_d = 4'd0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            bitcnt_q   <= 4'd0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            abrt_q     <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            bitcnt_q   <= bitcnt_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ovf_q      <= ovf_d;
            abrt_q     <= abrt_d;
`ifdef FRAME_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign busy = (state_q == StShift) || (state_q == StParity);

    always_comb begin
        io_out = 8'h00;
        case (view_sel)
            2'b00: io_out = data_q;
            2'b01: io_out = {rx_valid_q, perr_q, ovf_q, abrt_q, busy, bitcnt_q[2:0]};
            2'b10: io_out = shreg_q;
            2'b11: io_out = {state_q, bitcnt_q, 2'b00};
            default: io_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_user_module_serial_frame_rx.sv
// Scoreboard bench for user_module_serial_frame_rx: frames push expected words, a monitor
// pops them when the DUT commits. Parity bits are sent only when FRAME_RX_PARITY_EN is defined.
module tb_user_module_serial_frame_rx;

`ifdef FRAME_RX_PARITY_EN
    localparam bit ParityOn = 1'b1;
`else
    localparam bit ParityOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, din, din_valid, sync, rd;
    logic [1:0] view_sel;
    logic [7:0] io_in;
    logic [7:0] io_out;

    always #5 clk = ~clk;
    assign io_in = {view_sel, rd, sync, din_valid, din, rst_n, clk};

    user_module_serial_frame_rx dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ovf;
        logic       abrt;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Watch the state view; on DONE, read data and status right after the commit edge.
    initial begin
        logic [7:0] got_d, got_s;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_en && io_out[7:6] == 2'b11) begin
                view_sel = 2'b00;
                @(negedge clk);
                got_d = io_out;
                view_sel = 2'b01;
                #1;
                got_s = io_out;
                view_sel = 2'b11;
                check_eq("commit_expected", 8'(sb_q.size() != 0), 8'h01);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("data", got_d, e.data);
                    check_eq("status", {got_s[7:4], 4'h0}, {1'b1, e.perr, e.ovf, e.abrt, 4'h0});
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic s);
        din = b;
        din_valid = 1'b1;
        sync = s;
        @(negedge clk);
        din_valid = 1'b0;
        sync = 1'b0;
        din = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input int gap_after,
                              input logic exp_ovf, input logic exp_abrt);
        exp_t e;
        e.data = d;
        e.perr = ParityOn & flip;
        e.ovf  = exp_ovf;
        e.abrt = exp_abrt;
        sb_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], i == 0);
            if (i == gap_after) repeat (3) @(negedge clk);
        end
        if (ParityOn) send_bit((^d) ^ flip, 1'b0);
    endtask

    task automatic send_partial(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_bit(d[i], i == 0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain", 8'(sb_q.size()), 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0; rd = 1'b0;
        view_sel = 2'b00;
        repeat (2) @(negedge clk);

        // Reset state across all views
        for (int v = 0; v < 4; v++) begin
            view_sel = 2'(v);
            #1;
            check_eq($sformatf("reset_view%0d", v), io_out, 8'h00);
        end
        rst_n = 1'b1;
        @(negedge clk);
        view_sel = 2'b11;
        mon_en = 1'b1;

        // Stray bits without sync are ignored, then a clean 0xA5
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, -1, 1'b0, 1'b0);
        wait_drain();

        // Bad parity (no effect without parity), previous word unread -> ovf
        send_frame(8'hA5, 1'b1, -1, 1'b1, 1'b0);
        wait_drain();
        mon_en = 1'b0;
        rd_pulse();
        view_sel = 2'b01;
        #1;
        check_eq("rd_clear", io_out, 8'h00);
        view_sel = 2'b11;
        @(negedge clk);
        mon_en = 1'b1;

        // Back-to-back frames, gaps inside the first
        send_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, -1, 1'b1, 1'b0);
        wait_drain();

        // Sync re-asserted mid-frame aborts and restarts
        rd_pulse();
        send_partial(8'h0A, 4);
        send_frame(8'h0F, 1'b0, -1, 1'b0, 1'b1);
        wait_drain();

        // Reset mid-frame discards the partial word
        rd_pulse();
        send_partial(8'h55, 5);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h81, 1'b0, -1, 1'b0, 1'b0);
        wait_drain();

        // rd held through the commit edge: commit wins, ovf stays clear
        rd = 1'b1;
        send_frame(8'h5A, 1'b0, -1, 1'b0, 1'b0);
        @(negedge clk);
        rd = 1'b0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
